ct_spsram_req_ctrl: RTL and testbench

CT_SPSRAM_REQ_CTRL -- requirements
Module: ct_spsram_req_ctrl

---
 rtl/ct_spsram_req_ctrl.sv | 152 +++++++++++++++
 tb/tb_ct_spsram_req_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_spsram_req_ctrl.sv
// Request/response controller for a single-port SRAM macro with a 3-deep read-response FIFO.
// Optional power-up zero-fill sweep enabled by defining CT_SPSRAM_CTRL_INIT_EN.
module ct_spsram_req_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 88
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_bwen,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    typedef enum logic [1:0] {
        S_START,
        S_INIT,
        S_RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_WIDTH-1:0] r_initAddr;
    logic [ADDR_WIDTH-1:0] r_lastA;
    logic                  r_rdPend;
    logic [1:0]            r_count;
    logic [1:0]            r_wrPtr;
    logic [1:0]            r_rdPtr;
    logic [DATA_WIDTH-1:0] r_mem [0:2];

    logic       w_initing;
    logic       w_accept;
    logic       w_rdAccept;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_used;
    logic [1:0] w_credit;

    function automatic logic [1:0] nextPtr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_START: begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
                w_nextState = S_INIT;
`else
                w_nextState = S_RUN;
`endif
            end
            S_INIT: begin
                if (r_initAddr == {ADDR_WIDTH{1'b1}}) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN:   w_nextState = S_RUN;
            default: w_nextState = S_START;
        endcase
    end

    // Credit counts the read in the SRAM pipeline as well as buffered responses,
    // so every accepted read is guaranteed a FIFO slot when Q arrives.
    assign w_used     = r_count + {1'b0, r_rdPend};
    assign w_credit   = 2'd3 - w_used;
    assign init_done  = (r_state == S_RUN) & ~RST;
    assign req_rdy    = init_done & (w_credit != 2'd0);
    assign w_accept   = req_vld & req_rdy;
    assign w_rdAccept = w_accept & ~req_wr;
    assign w_initing  = (r_state == S_INIT) & ~RST;
    assign w_push     = r_rdPend;
    assign rsp_vld    = (r_count != 2'd0);
    assign w_pop      = rsp_vld & rsp_rdy;
    assign rsp_rdata  = r_mem[r_rdPtr];

    always_comb begin
        A    = r_lastA;
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = {DATA_WIDTH{1'b1}};
        D    = {DATA_WIDTH{1'b0}};
        if (w_initing) begin
            A    = r_initAddr;
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = {DATA_WIDTH{1'b0}};
        end else if (w_accept) begin
            A    = req_addr;
            CEN  = 1'b0;
            GWEN = ~req_wr;
            WEN  = ~req_bwen;
            D    = req_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_START;
            r_initAddr <= '0;
            r_lastA    <= '0;
            r_rdPend   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_lastA  <= A;
            r_rdPend <= w_rdAccept;
            if (w_initing) begin
                r_initAddr <= r_initAddr + ADDR_ONE;
            end
        end
    end

    // Q belongs to the read accepted one cycle earlier; capture it unconditionally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= 2'd0;
            r_wrPtr <= 2'd0;
            r_rdPtr <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= Q;
                r_wrPtr        <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_spsram_req_ctrl.sv
// Directed self-checking bench for ct_spsram_req_ctrl with a behavioural SRAM macro model.
module tb_ct_spsram_req_ctrl;

    localparam int AW    = 11;
    localparam int DW    = 88;
    localparam int DEPTH = 2048;
    localparam logic [DW-1:0] FILL = 88'h0BAD_0000_0000_0000_00BAD;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_bwen;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] A;
    logic          CEN;
    logic          GWEN;
    logic [DW-1:0] WEN;
    logic [DW-1:0] D;
    logic [DW-1:0] Q;

    logic [DW-1:0] sram [0:DEPTH-1];
    logic [DW-1:0] rspQ [$];
    int vecCount  = 0;
    int missCount = 0;

    ct_spsram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_bwen(req_bwen),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
    );

    always #5 CLK = ~CLK;

    // Single-port SRAM macro: bit-masked write, registered read data.
    always @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
            else       Q <= sram[A];
        end
    end

    always @(negedge CLK) begin
        if (rsp_vld && rsp_rdy) rspQ.push_back(rsp_rdata);
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] patt(input logic [AW-1:0] a);
        return {8'h5A, 69'd0, a};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] bwen);
        int waitCnt;
        logic expGwen;
        logic [DW-1:0] expWen;
        expGwen   = ~wr;
        expWen    = ~bwen;
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_bwen  = bwen;
        waitCnt   = 0;
        @(negedge CLK);
        while (!req_rdy && waitCnt < 50) begin
            @(negedge CLK);
            waitCnt++;
        end
        if (!req_rdy) begin
            checkOutput("acceptTimeout", 0, 1);
        end else begin
            checkOutput("pinCEN", CEN, 0);
            checkOutput("pinGWEN", GWEN, expGwen);
            checkOutput("pinA", A, addr);
            if (wr) begin
                checkOutput("pinWEN", WEN, expWen);
                checkOutput("pinD", D, wdata);
            end
        end
        tick();
        req_vld = 1'b0;
        req_wr  = 1'b0;
    endtask

    task automatic waitRsp(input int n);
        int w;
        w = 0;
        while (rspQ.size() < n && w < 200) begin
            @(negedge CLK);
            w++;
        end
        if (rspQ.size() < n) checkOutput("rspTimeout", rspQ.size(), n);
    endtask

    task automatic waitInitDone(output int cyc, output logic vldSeen);
        logic done;
        done    = 1'b0;
        vldSeen = 1'b0;
        cyc     = 0;
        while (!done && cyc < 5000) begin
            @(negedge CLK);
            if (rsp_vld) vldSeen = 1'b1;
            if (init_done) begin
                done = 1'b1;
            end else begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
                if (cyc == 1000) begin
                    checkOutput("rdyDuringInit", req_rdy, 0);
                    checkOutput("cenDuringInit", CEN, 0);
                end
`endif
                @(posedge CLK);
                cyc++;
            end
        end
    endtask

    initial begin
        int cyc;
        int accepted;
        int drops;
        int w;
        int expCycle;
        logic vldSeen;
        logic [DW-1:0] expData;

`ifdef CT_SPSRAM_CTRL_INIT_EN
        expCycle = 2049;
`else
        expCycle = 1;
`endif
        for (int i = 0; i < DEPTH; i++) sram[i] = FILL;
        RST = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; req_bwen = '0; rsp_rdy = 1'b1;
        repeat (3) @(posedge CLK);

        @(negedge CLK);
        checkOutput("rstReqRdy", req_rdy, 0);
        checkOutput("rstRspVld", rsp_vld, 0);
        checkOutput("rstRdata", rsp_rdata, 0);
        checkOutput("rstCEN", CEN, 1);
        checkOutput("rstGWEN", GWEN, 1);
        checkOutput("rstWEN", WEN, {DW{1'b1}});
        checkOutput("rstD", D, 0);
        checkOutput("rstA", A, 0);
        checkOutput("rstInitDone", init_done, 0);

        tick();
        RST = 1'b0;
        waitInitDone(cyc, vldSeen);
        checkOutput("initDoneCycle", cyc, expCycle);
        checkOutput("rdyAfterInit", req_rdy, 1);
        tick();

        // Top address: zero after the init sweep, untouched fill otherwise.
        applyStimulus(1'b0, 11'h7FF, '0, '0);
        waitRsp(1);
`ifdef CT_SPSRAM_CTRL_INIT_EN
        expData = '0;
`else
        expData = FILL;
`endif
        if (rspQ.size() > 0) checkOutput("read7FF", rspQ[0], expData);
        rspQ.delete();
        tick();

        // Full write then read-back with two-cycle response latency.
        applyStimulus(1'b1, 11'h005, 88'h123456789ABCDEF012345, {DW{1'b1}});
        applyStimulus(1'b0, 11'h005, '0, '0);
        @(negedge CLK);
        checkOutput("rspNotEarly", rsp_vld, 0);
        @(negedge CLK);
        checkOutput("rspLatency", rsp_vld, 1);
        checkOutput("rspData005", rsp_rdata, 88'h123456789ABCDEF012345);
        tick();
        rspQ.delete();

        // Bit-masked write clears only the low byte.
        applyStimulus(1'b1, 11'h00A, {DW{1'b1}}, {DW{1'b1}});
        applyStimulus(1'b1, 11'h00A, '0, 88'hFF);
        applyStimulus(1'b0, 11'h00A, '0, '0);
        waitRsp(1);
        expData = {{80{1'b1}}, 8'h00};
        if (rspQ.size() > 0) checkOutput("maskedWrite", rspQ[0], expData);
        rspQ.delete();
        tick();

        for (int a = 16'h010; a < 16'h01A; a++) applyStimulus(1'b1, AW'(a), patt(AW'(a)), {DW{1'b1}});
        for (int a = 16'h100; a < 16'h164; a++) applyStimulus(1'b1, AW'(a), patt(AW'(a)), {DW{1'b1}});

        // Back-pressure: only three reads fit while the consumer stalls.
        rsp_rdy = 1'b0; accepted = 0; req_vld = 1'b1; req_wr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            req_addr = AW'(16'h010 + accepted);
            @(negedge CLK);
            if (req_rdy) accepted++;
            tick();
        end
        checkOutput("stallAccepted", accepted, 3);
        req_addr = AW'(16'h010 + accepted);
        @(negedge CLK);
        checkOutput("stallRdy", req_rdy, 0);
        checkOutput("stallVld", rsp_vld, 1);
        checkOutput("holdData1", rsp_rdata, patt(11'h010));
        tick();
        @(negedge CLK);
        checkOutput("holdData2", rsp_rdata, patt(11'h010));
        tick();
        rsp_rdy = 1'b1; w = 0;
        while (accepted < 10 && w < 100) begin
            req_addr = AW'(16'h010 + accepted);
            @(negedge CLK);
            if (req_rdy) accepted++;
            tick();
            w++;
        end
        req_vld = 1'b0;
        checkOutput("stallAllAccepted", accepted, 10);
        waitRsp(10);
        checkOutput("stallRspCount", rspQ.size(), 10);
        for (int i = 0; i < 10 && i < rspQ.size(); i++) checkOutput("stallOrder", rspQ[i], patt(AW'(16'h010 + i)));
        rspQ.delete();
        tick();

        // Streaming: one read per cycle with no ready drop.
        rsp_rdy = 1'b1; accepted = 0; drops = 0; w = 0; req_vld = 1'b1; req_wr = 1'b0;
        while (accepted < 100 && w < 300) begin
            req_addr = AW'(16'h100 + accepted);
            @(negedge CLK);
            if (req_rdy) accepted++;
            else drops++;
            tick();
            w++;
        end
        req_vld = 1'b0;
        checkOutput("streamDrops", drops, 0);
        checkOutput("streamAccepted", accepted, 100);
        waitRsp(100);
        checkOutput("streamRspCount", rspQ.size(), 100);
        for (int i = 0; i < 100 && i < rspQ.size(); i++) checkOutput("streamOrder", rspQ[i], patt(AW'(16'h100 + i)));
        rspQ.delete();
        tick();

        // Reset with one read in the SRAM pipe and one buffered.
        rsp_rdy = 1'b0;
        applyStimulus(1'b0, 11'h010, '0, '0);
        applyStimulus(1'b0, 11'h011, '0, '0);
        RST = 1'b1;
        tick();
        @(negedge CLK);
        checkOutput("midRstVld", rsp_vld, 0);
        checkOutput("midRstRdata", rsp_rdata, 0);
        checkOutput("midRstRdy", req_rdy, 0);
        checkOutput("midRstCEN", CEN, 1);
        checkOutput("midRstGWEN", GWEN, 1);
        checkOutput("midRstWEN", WEN, {DW{1'b1}});
        checkOutput("midRstD", D, 0);
        checkOutput("midRstA", A, 0);
        checkOutput("midRstInitDone", init_done, 0);
        tick();
        RST = 1'b0;
        rsp_rdy = 1'b1;
        waitInitDone(cyc, vldSeen);
        checkOutput("reinitCycle", cyc, expCycle);
        repeat (5) begin
            @(negedge CLK);
            if (rsp_vld) vldSeen = 1'b1;
        end
        checkOutput("noRspAfterRst", vldSeen, 0);
        checkOutput("noRspQueued", rspQ.size(), 0);
        checkOutput("idleCEN", CEN, 1);
        checkOutput("idleWEN", WEN, {DW{1'b1}});

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
